fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-issue sequencer for the 8-bit RISC CPU. It owns the 5-bit program counter, reads one 8-bit instruction word per instruction, and presents the opcode and operand address to the downstream operand-address storage and execute logic. It holds each instruction for its opcode-defined cycle count, then computes the next PC from the instruction and the ALU zero flag.

## Interface
- No parameters. Widths are fixed: 5-bit address, 3-bit opcode, 8-bit instruction.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  8  instruction word at `mem[pc]`. The memory read is combinational, so `instr` is valid in the same cycle as `pc`. Bits [7:5] are the opcode and bits [4:0] are the operand.
- zero  input  1  ALU accumulator-zero flag. Sampled only as described under Operation.
- start  input  1  single-cycle pulse that resumes execution from HALT.
- bp_addr  input  5  breakpoint address. Used only when `FETCH_BREAKPOINT_EN` is defined.
- pc  output  5  program counter; the memory read address.
- opcode_out  output  3  latched opcode of the current instruction.
- addr_out  output  5  latched operand address of the current instruction.
- issue  output  1  one-cycle pulse marking the first cycle of a new instruction.
- halted  output  1  high while in HALT.
- bp_hit  output  1  one-cycle pulse when a breakpoint is taken.

## Operation
- Opcodes:
  - HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- Hold count N per opcode:
  - HLT 0, SKZ 3, ADD/AND/XOR/LDA 5, STO 4, JMP 3.
  - Each instruction occupies N+1 cycles: 1 FETCH cycle plus N HOLD cycles.
- States: FETCH, HOLD, HALT. A 3-bit down-counter `cnt` tracks the HOLD cycles.
- FETCH, on the clock edge:
  - Latch `opcode_out <= instr[7:5]`, `addr_out <= instr[4:0]`, `issue <= 1`.
  - If the opcode is HLT: go to HALT and set `halted <= 1`.
  - Otherwise: set `cnt <= N` and go to HOLD.
- HOLD, on each edge:
  - If `cnt != 1`: `cnt <= cnt - 1`.
  - If `cnt == 1`: update `pc`, set `cnt <= 0`, go to FETCH.
  - `zero` is sampled on this final HOLD edge only.
- Next-PC rules:
  - JMP: `pc <= addr_out`.
  - SKZ with `zero=1`: `pc <= pc + 2`.
  - All other cases: `pc <= pc + 1`.
  - All PC arithmetic is modulo 32: 31+1 wraps to 0, and 31+2 wraps to 1.
- HALT:
  - `pc`, `opcode_out` and `addr_out` hold their values.
  - A `start` pulse sets `pc <= pc + 1` and `halted <= 0`, and moves to FETCH.
  - `start` is ignored in FETCH and HOLD.
- `issue` is high for exactly one cycle per instruction, including HLT.
- `opcode_out` and `addr_out` are stable for all N+1 cycles of the instruction.

## Timing
- Reset values: `pc=0`, `opcode_out=0`, `addr_out=0`, `issue=0`, `halted=0`, `bp_hit=0`, `cnt=0`, state FETCH.
- Reset mid-instruction abandons the instruction immediately. The first FETCH is the cycle after `rst` deasserts.
- Issue latency: `issue`, `opcode_out` and `addr_out` are valid the cycle after the FETCH cycle in which `instr` was sampled.
- Next-instruction spacing is N+1 cycles: SKZ and JMP 4, STO 5, ALU and LDA 6.
- `rst` has priority over `start` and over any breakpoint.
- When `start` and `zero` change in the same cycle, only `start` has an effect, and only in HALT.

## Configuration
- `FETCH_BREAKPOINT_EN` defined:
  - In FETCH, if `pc == bp_addr`, the instruction is not issued.
  - `issue` stays 0; `bp_hit` pulses for 1 cycle; `halted <= 1`; state goes to HALT.
  - `pc` is unchanged.
  - On `start`, the instruction at `bp_addr` executes without re-triggering the breakpoint. A one-shot skip flag is set on resume and cleared at the next FETCH.
  - Note the difference from HLT: resuming from a breakpoint does not increment `pc`.
- `FETCH_BREAKPOINT_EN` undefined:
  - `bp_addr` is ignored and `bp_hit` is tied to 0.

## Test plan
- Reset, then SKZ (8'h20) at `pc=0` with `zero=1` → `issue` at cycle 1, `opcode_out=001`; `pc=2` after 4 cycles.
- Same SKZ with `zero=0` → `pc=1` after 4 cycles.
- JMP 8'hF7 at `pc=3` → `addr_out=5'h17`, `pc=5'h17` 4 cycles after FETCH.
- ADD then STO sequence → `issue` pulses 6 cycles apart, then 5 cycles apart; `opcode_out` is stable throughout each instruction.
- HLT 8'h00 at `pc=31` → `halted=1`, `pc` holds at 31 for 10 cycles; `start` → `pc=0`, FETCH resumes.
- Assert `rst` during the 3rd HOLD cycle of LDA at `pc=9` → next cycle `pc=0`, `issue=0`; the bench checks all reset values.
- With `FETCH_BREAKPOINT_EN` and `bp_addr=2` → `bp_hit` pulses when `pc=2`, no `issue`, `halted=1`; after `start`, the instruction at address 2 issues once.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-issue sequencer: PC, fetch/hold timing, next-PC, HALT
// Optional breakpoint support under `FETCH_BREAKPOINT_EN.
module fetch_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       zero,
    input  logic       start,
    input  logic [4:0] bp_addr,
    output logic [4:0] pc,
    output logic [2:0] opcode_out,
    output logic [4:0] addr_out,
    output logic       issue,
    output logic       halted,
    output logic       bp_hit
);
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    typedef enum logic [1:0] {FETCH, HOLD, HALT} state_t;

    state_t     state;
    logic [2:0] cnt;
    logic       bp_take;

    function automatic logic [2:0] hold_count(input logic [2:0] op);
        case (op)
            OP_HLT:         hold_count = 3'd0;
            OP_SKZ, OP_JMP: hold_count = 3'd3;
            OP_STO:         hold_count = 3'd4;
            default:        hold_count = 3'd5;
        endcase
    endfunction

`ifdef FETCH_BREAKPOINT_EN
    logic bp_skip;
    logic bp_halt;
    logic bp_hit_q;

    // The skip flag lets the instruction at the breakpoint run once after resume.
    assign bp_take = (pc == bp_addr) && !bp_skip;
    assign bp_hit  = bp_hit_q;
`else
    logic unused_bp;

    assign unused_bp = ^bp_addr;
    assign bp_take   = 1'b0;
    assign bp_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= 5'd0;
            opcode_out <= 3'd0;
            addr_out   <= 5'd0;
            issue      <= 1'b0;
            halted     <= 1'b0;
            cnt        <= 3'd0;
`ifdef FETCH_BREAKPOINT_EN
            bp_skip    <= 1'b0;
            bp_halt    <= 1'b0;
            bp_hit_q   <= 1'b0;
`endif
        end else begin
            issue <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
            bp_hit_q <= 1'b0;
`endif
            case (state)
                FETCH: begin
                    if (bp_take) begin
                        halted <= 1'b1;
                        state  <= HALT;
`ifdef FETCH_BREAKPOINT_EN
                        bp_hit_q <= 1'b1;
                        bp_halt  <= 1'b1;
`endif
                    end else begin
`ifdef FETCH_BREAKPOINT_EN
                        bp_skip <= 1'b0;
`endif
                        opcode_out <= instr[7:5];
                        addr_out   <= instr[4:0];
                        issue      <= 1'b1;
                        if (instr[7:5] == OP_HLT) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            cnt   <= hold_count(instr[7:5]);
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (cnt != 3'd1) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        cnt   <= 3'd0;
                        state <= FETCH;
                        if (opcode_out == OP_JMP)
                            pc <= addr_out;
                        else if (opcode_out == OP_SKZ && zero)
                            pc <= pc + 5'd2;
                        else
                            pc <= pc + 5'd1;
                    end
                end
                HALT: begin
                    if (start) begin
                        halted <= 1'b0;
                        state  <= FETCH;
`ifdef FETCH_BREAKPOINT_EN
                        // Breakpoint resume re-fetches the same address instead of advancing.
                        if (bp_halt) begin
                            bp_halt <= 1'b0;
                            bp_skip <= 1'b1;
                        end else begin
                            pc <= pc + 5'd1;
                        end
`else
                        pc <= pc + 5'd1;
`endif
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr;
    logic       zero = 1'b0;
    logic       start = 1'b0;
    logic [4:0] bp_addr = 5'd20;
    logic [4:0] pc;
    logic [2:0] opcode_out;
    logic [4:0] addr_out;
    logic       issue;
    logic       halted;
    logic       bp_hit;

    logic [7:0] mem [0:31];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] pc;
        logic [2:0] op;
        logic [4:0] addr;
        int         gap;
    } exp_t;
    exp_t sb[$];

    assign instr = mem[pc];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .start(start),
        .bp_addr(bp_addr), .pc(pc), .opcode_out(opcode_out), .addr_out(addr_out),
        .issue(issue), .halted(halted), .bp_hit(bp_hit)
    );

    always #5 clk = ~clk;

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    endtask

    task automatic expect_issue(input logic [4:0] p, input logic [2:0] op,
                                input logic [4:0] a, input int gap);
        exp_t e;
        e.pc = p; e.op = op; e.addr = a; e.gap = gap;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consume n issue pulses, checking pc/opcode/operand, spacing, and operand stability.
    task automatic run_issues(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        int since = 0;
        bit have = 0;
        logic [2:0] cur_op;
        logic [4:0] cur_addr;
        exp_t e;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            since++;
            if (issue) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue pc=%0d op=%0d", pc, opcode_out);
                end else begin
                    e = sb.pop_front();
                    if (pc !== e.pc || opcode_out !== e.op || addr_out !== e.addr) begin
                        errors++;
                        $display("FAIL issue_fields got pc=%0d op=%0d addr=%0d want pc=%0d op=%0d addr=%0d",
                                 pc, opcode_out, addr_out, e.pc, e.op, e.addr);
                    end
                    if (e.gap > 0) begin
                        checks++;
                        if (since !== e.gap) begin
                            errors++;
                            $display("FAIL issue_spacing got %0d want %0d", since, e.gap);
                        end
                    end
                    cur_op = e.op;
                    cur_addr = e.addr;
                end
                since = 0;
                have = 1;
                got++;
            end else if (have) begin
                checks++;
                if (opcode_out !== cur_op || addr_out !== cur_addr) begin
                    errors++;
                    $display("FAIL operand_stable got op=%0d addr=%0d want op=%0d addr=%0d",
                             opcode_out, addr_out, cur_op, cur_addr);
                end
            end
        end
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL issue_timeout got %0d issues want %0d", got, n);
        end
    endtask

    task automatic check_pc_halt(input string name, input logic [4:0] p, input logic h);
        checks++;
        if (pc !== p || halted !== h) begin
            errors++;
            $display("FAIL %s got pc=%0d halted=%0b want pc=%0d halted=%0b", name, pc, halted, p, h);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (pc !== 5'd0 || opcode_out !== 3'd0 || addr_out !== 5'd0 ||
            issue !== 1'b0 || halted !== 1'b0 || bp_hit !== 1'b0) begin
            errors++;
            $display("FAIL %s got pc=%0d op=%0d addr=%0d issue=%0b halted=%0b bp_hit=%0b",
                     name, pc, opcode_out, addr_out, issue, halted, bp_hit);
        end
    endtask

    task automatic test_reset();
        clear_mem();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset_values");
        rst = 1'b0;
        expect_issue(5'd0, 3'd0, 5'd0, 0);
        run_issues(1, 3);
        check_pc_halt("hlt_at_0", 5'd0, 1'b1);
    endtask

    task automatic test_skz(input logic z);
        clear_mem();
        mem[0] = 8'h20;
        zero = z;
        do_reset();
        expect_issue(5'd0, 3'd1, 5'd0, 0);
        expect_issue(z ? 5'd2 : 5'd1, 3'd0, 5'd0, 4);
        run_issues(2, 12);
        check_pc_halt(z ? "skz_taken" : "skz_not_taken", z ? 5'd2 : 5'd1, 1'b1);
        zero = 1'b0;
    endtask

    task automatic test_jmp();
        clear_mem();
        mem[0]  = 8'hE3;
        mem[3]  = 8'hF7;
        do_reset();
        expect_issue(5'd0, 3'd7, 5'd3, 0);
        expect_issue(5'd3, 3'd7, 5'h17, 4);
        expect_issue(5'h17, 3'd0, 5'd0, 4);
        run_issues(3, 16);
        check_pc_halt("jmp_target", 5'h17, 1'b1);
    endtask

    task automatic test_back_to_back();
        clear_mem();
        mem[0] = 8'h41;
        mem[1] = 8'hC2;
        do_reset();
        expect_issue(5'd0, 3'd2, 5'd1, 0);
        expect_issue(5'd1, 3'd6, 5'd2, 6);
        expect_issue(5'd2, 3'd0, 5'd0, 5);
        run_issues(3, 20);
        check_pc_halt("add_sto_end", 5'd2, 1'b1);
    endtask

    task automatic test_halt_wrap();
        clear_mem();
        mem[0] = 8'hFF;
        do_reset();
        expect_issue(5'd0, 3'd7, 5'd31, 0);
        expect_issue(5'd31, 3'd0, 5'd0, 4);
        run_issues(2, 12);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_pc_halt("halt_hold", 5'd31, 1'b1);
        end
        pulse_start();
        check_pc_halt("start_wrap", 5'd0, 1'b0);
        expect_issue(5'd0, 3'd7, 5'd31, 0);
        run_issues(1, 2);
    endtask

    task automatic test_mid_reset();
        clear_mem();
        mem[0] = 8'hE9;
        mem[9] = 8'hA4;
        do_reset();
        expect_issue(5'd0, 3'd7, 5'd9, 0);
        expect_issue(5'd9, 3'd5, 5'd4, 4);
        run_issues(2, 12);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (pc !== 5'd9 || opcode_out !== 3'd5 || issue !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL lda_hold got pc=%0d op=%0d issue=%0b halted=%0b", pc, opcode_out, issue, halted);
        end
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_instr_reset");
        rst = 1'b0;
    endtask

`ifdef FETCH_BREAKPOINT_EN
    task automatic test_breakpoint();
        int cyc = 0;
        clear_mem();
        mem[0] = 8'hE2;
        mem[2] = 8'h45;
        bp_addr = 5'd2;
        do_reset();
        expect_issue(5'd0, 3'd7, 5'd2, 0);
        run_issues(1, 3);
        while (!bp_hit && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (bp_hit !== 1'b1 || issue !== 1'b0 || halted !== 1'b1 || pc !== 5'd2) begin
            errors++;
            $display("FAIL bp_take got bp_hit=%0b issue=%0b halted=%0b pc=%0d", bp_hit, issue, halted, pc);
        end
        @(negedge clk);
        checks++;
        if (bp_hit !== 1'b0) begin
            errors++;
            $display("FAIL bp_pulse got %0b want 0", bp_hit);
        end
        pulse_start();
        check_pc_halt("bp_resume", 5'd2, 1'b0);
        expect_issue(5'd2, 3'd2, 5'd5, 0);
        expect_issue(5'd3, 3'd0, 5'd0, 6);
        run_issues(2, 12);
        check_pc_halt("bp_after", 5'd3, 1'b1);
        bp_addr = 5'd20;
    endtask
`endif

    initial begin
        test_reset();
        test_skz(1'b1);
        test_skz(1'b0);
        test_jmp();
        test_back_to_back();
        test_halt_wrap();
        test_mid_reset();
`ifdef FETCH_BREAKPOINT_EN
        test_breakpoint();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
